// File: rtl/cdcm_rx_init_ctrl.sv
// -----------------------------------------------------------------------------
// cdcm_rx_init_ctrl
// Link-initialisation sequencer for one CDCM 8:1 receive lane. It sweeps all 32
// IDELAY coarse taps and grades each tap by word stability. It keeps the first
// widest run of good taps, loads the centre of that run, and then bitslips until
// the deserialised word equals the idle pattern. Finally it re-enables VTC and
// flags done.
//
// Ports
//   clkDivIn      in   word clock, all logic on the rising edge
//   ioReset       in   synchronous active-high reset
//   initStart     in   1-cycle start/restart pulse (honoured in IDLE/DONE/ERROR)
//   dOutToDevice  in   deserialised word from the rx lane (post-bitslip mux)
//   tapIn         out  coarse tap to load (CNTVALUEIN = {tapIn,4'h0})
//   rstIDelay     out  1-cycle LOAD strobe to the delay lines
//   EN_VTC        out  VTC enable to the delay lines
//   bitslip       out  1-cycle bitslip strobe
//   initDone      out  lane aligned, held until restart/reset
//   initError     out  no eye or no pattern lock, held until restart/reset
//   bestTap       out  chosen centre tap
//   windowLen     out  length of the chosen window (0..32)
// -----------------------------------------------------------------------------
module cdcm_rx_init_ctrl #(
  parameter int unsigned             kDevW        = 8,
  parameter logic [kDevW-1:0]        kIdlePattern = 8'h5C,
  parameter int unsigned             kVtcWait     = 16,
  parameter int unsigned             kSettleCyc   = 8,
  parameter int unsigned             kCheckCyc    = 256,
  parameter int unsigned             kMinWindow   = 4
) (
  input  logic             clkDivIn,
  input  logic             ioReset,
  input  logic             initStart,
  input  logic [kDevW-1:0] dOutToDevice,
  output logic [4:0]       tapIn,
  output logic             rstIDelay,
  output logic             EN_VTC,
  output logic             bitslip,
  output logic             initDone,
  output logic             initError,
  output logic [4:0]       bestTap,
  output logic [5:0]       windowLen
);

  // One shared wait/sample counter sized for the longest interval.
  localparam int unsigned kCntMaxA = (kVtcWait > kSettleCyc) ? kVtcWait : kSettleCyc;
  localparam int unsigned kCntMax  = (kCntMaxA > kCheckCyc) ? kCntMaxA : kCheckCyc;
  localparam int unsigned kCntW    = $clog2(kCntMax + 1);
  localparam int unsigned kSlipW   = (kDevW > 1) ? $clog2(kDevW) : 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_VTC_OFF,
    ST_LOAD,
    ST_SETTLE,
    ST_CHECK,
    ST_CENTRE,
    ST_ALIGN_CHK,
    ST_VTC_ON,
    ST_DONE,
    ST_ERROR
  } state_e;

  state_e             state_q;
  logic [kCntW-1:0]   cnt_q;
  logic [4:0]         tap_q;
  logic               rst_idelay_q;
  logic               en_vtc_q;
  logic               bitslip_q;
  logic               done_q;
  logic               error_q;
  logic [4:0]         best_tap_q;
  logic [5:0]         window_len_q;
  logic [5:0]         run_len_q;
  logic [4:0]         run_start_q;
  logic [5:0]         best_len_q;
  logic [4:0]         best_start_q;
  logic [kDevW-1:0]   word_ref_q;
  logic               tap_bad_q;
  logic               from_scan_q;
  logic [kSlipW-1:0]  slip_cnt_q;

  // Grade of the tap being closed out and the resulting run/centre values.
  logic       tap_good_c;
  logic [5:0] run_len_nxt_c;
  logic [4:0] run_start_nxt_c;
  logic [4:0] centre_c;

  always_comb begin
    tap_good_c      = !tap_bad_q && (dOutToDevice == word_ref_q);
    run_len_nxt_c   = tap_good_c ? (run_len_q + 6'd1) : 6'd0;
    run_start_nxt_c = (tap_good_c && (run_len_q == 6'd0)) ? tap_q : run_start_q;
    // best_start + floor(best_len/2) never exceeds 31 for a run inside 0..31.
    centre_c        = 5'(6'(best_start_q) + (best_len_q >> 1));
  end

  // Sequencer: scan, centre, align, then hand VTC back to the delay lines.
  always_ff @(posedge clkDivIn) begin
    if (ioReset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      tap_q        <= '0;
      rst_idelay_q <= 1'b0;
      en_vtc_q     <= 1'b1;
      bitslip_q    <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      best_tap_q   <= '0;
      window_len_q <= '0;
      run_len_q    <= '0;
      run_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
      word_ref_q   <= '0;
      tap_bad_q    <= 1'b0;
      from_scan_q  <= 1'b1;
      slip_cnt_q   <= '0;
    end else begin
      // Strobes are single-cycle: they drop unless re-armed below.
      rst_idelay_q <= 1'b0;
      bitslip_q    <= 1'b0;

      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (initStart) begin
            state_q      <= ST_VTC_OFF;
            en_vtc_q     <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            tap_q        <= '0;
            best_tap_q   <= '0;
            window_len_q <= '0;
            run_len_q    <= '0;
            run_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
            tap_bad_q    <= 1'b0;
            slip_cnt_q   <= '0;
            from_scan_q  <= 1'b1;
            cnt_q        <= '0;
          end
        end

        ST_VTC_OFF: begin
          if (cnt_q == kCntW'(kVtcWait - 1)) begin
            cnt_q   <= '0;
            state_q <= ST_LOAD;
          end else begin
            cnt_q <= cnt_q + kCntW'(1);
          end
        end

        // tapIn was updated on entry here, so it is stable a cycle before the strobe.
        ST_LOAD: begin
          rst_idelay_q <= 1'b1;
          cnt_q        <= '0;
          state_q      <= ST_SETTLE;
        end

        ST_SETTLE: begin
          if (cnt_q == kCntW'(kSettleCyc - 1)) begin
            cnt_q   <= '0;
            state_q <= from_scan_q ? ST_CHECK : ST_ALIGN_CHK;
          end else begin
            cnt_q <= cnt_q + kCntW'(1);
          end
        end

        // First word is the reference; every later word must match it.
        ST_CHECK: begin
          if (cnt_q == '0) begin
            word_ref_q <= dOutToDevice;
            tap_bad_q  <= 1'b0;
            cnt_q      <= cnt_q + kCntW'(1);
          end else if (cnt_q != kCntW'(kCheckCyc - 1)) begin
            if (dOutToDevice != word_ref_q) begin
              tap_bad_q <= 1'b1;
            end
            cnt_q <= cnt_q + kCntW'(1);
          end else begin
            cnt_q       <= '0;
            run_len_q   <= run_len_nxt_c;
            run_start_q <= run_start_nxt_c;
            // Strict compare keeps the earliest of equally wide windows.
            if (run_len_nxt_c > best_len_q) begin
              best_len_q   <= run_len_nxt_c;
              best_start_q <= run_start_nxt_c;
            end
            if (tap_q == 5'd31) begin
              state_q <= ST_CENTRE;
            end else begin
              tap_q   <= tap_q + 5'd1;
              state_q <= ST_LOAD;
            end
          end
        end

        ST_CENTRE: begin
          if (best_len_q < 6'(kMinWindow)) begin
            state_q  <= ST_ERROR;
            error_q  <= 1'b1;
            en_vtc_q <= 1'b1;
          end else begin
            best_tap_q   <= centre_c;
            window_len_q <= best_len_q;
            tap_q        <= centre_c;
            slip_cnt_q   <= '0;
            from_scan_q  <= 1'b0;
            state_q      <= ST_LOAD;
          end
        end

        // Every word of the window must equal the idle pattern; otherwise slip once.
        ST_ALIGN_CHK: begin
          if (dOutToDevice != kIdlePattern) begin
            cnt_q <= '0;
            if (slip_cnt_q == kSlipW'(kDevW - 1)) begin
              state_q  <= ST_ERROR;
              error_q  <= 1'b1;
              en_vtc_q <= 1'b1;
            end else begin
              bitslip_q  <= 1'b1;
              slip_cnt_q <= slip_cnt_q + kSlipW'(1);
              state_q    <= ST_SETTLE;
            end
          end else if (cnt_q == kCntW'(kCheckCyc - 1)) begin
            cnt_q    <= '0;
            en_vtc_q <= 1'b1;
            state_q  <= ST_VTC_ON;
          end else begin
            cnt_q <= cnt_q + kCntW'(1);
          end
        end

        ST_VTC_ON: begin
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tapIn     = tap_q;
  assign rstIDelay = rst_idelay_q;
  assign EN_VTC    = en_vtc_q;
  assign bitslip   = bitslip_q;
  assign initDone  = done_q;
  assign initError = error_q;
  assign bestTap   = best_tap_q;
  assign windowLen = window_len_q;

endmodule

// File: tb/tb_cdcm_rx_init_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cdcm_rx_init_ctrl
// Scoreboard bench for the lane init sequencer. A behavioural lane model serves
// stable words on good taps and randomly glitching words elsewhere, and it
// rotates the idle word by the number of bitslips seen. Expected completions
// come from a run-list model of the tap mask. They are queued at start and
// compared by an independent monitor on each done/error rising edge.
// -----------------------------------------------------------------------------
module tb_cdcm_rx_init_ctrl;

  localparam int unsigned kSettle = 8;
  localparam int unsigned kRunMax = 12000;

  logic       clk = 1'b0;
  logic       ioReset;
  logic       initStart;
  logic [7:0] dout;
  logic [4:0] tapIn;
  logic       rstIDelay;
  logic       EN_VTC;
  logic       bitslip;
  logic       initDone;
  logic       initError;
  logic [4:0] bestTap;
  logic [5:0] windowLen;

  always #5 clk = ~clk;

  cdcm_rx_init_ctrl dut (
    .clkDivIn     (clk),
    .ioReset      (ioReset),
    .initStart    (initStart),
    .dOutToDevice (dout),
    .tapIn        (tapIn),
    .rstIDelay    (rstIDelay),
    .EN_VTC       (EN_VTC),
    .bitslip      (bitslip),
    .initDone     (initDone),
    .initError    (initError),
    .bestTap      (bestTap),
    .windowLen    (windowLen)
  );

  typedef struct {
    bit         done;
    bit         err;
    logic [4:0] best;
    logic [5:0] wlen;
    int         slips;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- lane model ----------------
  logic [31:0] good_mask = '0;
  int          rot       = 0;
  bit          nomatch   = 1'b0;
  logic [4:0]  cur_tap   = '0;
  int          nslip     = 0;

  function automatic logic [7:0] rotl8(input logic [7:0] w, input int r);
    logic [15:0] t;
    t = {w, w};
    t = t << (r & 7);
    return t[15:8];
  endfunction

  always @(posedge clk) begin
    if (ioReset) begin
      cur_tap <= '0;
      nslip   <= 0;
    end else begin
      if (initStart)    nslip <= 0;
      else if (bitslip) nslip <= nslip + 1;
      if (rstIDelay)    cur_tap <= tapIn;
    end
  end

  always @(negedge clk) begin
    logic [7:0] base;
    base = rotl8(nomatch ? 8'hA5 : 8'h5C, rot - nslip);
    if (good_mask[cur_tap] || ($urandom_range(0, 3) != 0)) dout = base;
    else dout = base ^ 8'($urandom_range(1, 255));
  end

  // ---------------- reference model ----------------
  // Enumerate maximal runs of good taps; keep the first strictly longest.
  function automatic exp_t model(input logic [31:0] m, input int r, input bit nm);
    exp_t e;
    int   bs = 0;
    int   bl = 0;
    bit   prev = 1'b0;
    for (int s = 0; s < 32; s++) begin
      if (m[s] && !prev) begin
        int l = 0;
        while ((s + l < 32) && m[s + l]) l++;
        if (l > bl) begin
          bl = l;
          bs = s;
        end
      end
      prev = m[s];
    end
    e.best  = '0;
    e.wlen  = '0;
    e.slips = 0;
    if (bl < 4) begin
      e.done = 1'b0;
      e.err  = 1'b1;
    end else begin
      e.best = 5'(bs + bl / 2);
      e.wlen = 6'(bl);
      if (nm) begin
        e.done  = 1'b0;
        e.err   = 1'b1;
        e.slips = 7;
      end else begin
        e.done  = 1'b1;
        e.err   = 1'b0;
        e.slips = r;
      end
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  int cyc       = 0;
  int last_slip = -1;
  int done_cnt  = 0;
  bit prev_done = 1'b0;
  bit prev_err  = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!ioReset) begin
      if (rstIDelay || bitslip) begin
        check("strobe_vtc_low", int'(EN_VTC), 0);
        check("strobe_exclusive", int'(rstIDelay && bitslip), 0);
      end
      if (bitslip) begin
        if (last_slip >= 0) check("slip_gap", int'((cyc - last_slip) >= kSettle), 1);
        last_slip = cyc;
      end
      if (EN_VTC) last_slip = -1;
      if ((initDone && !prev_done) || (initError && !prev_err)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: got done=%0d err=%0d expected none", initDone, initError);
        end else begin
          e = exp_q.pop_front();
          check("initDone", int'(initDone), int'(e.done));
          check("initError", int'(initError), int'(e.err));
          check("bestTap", int'(bestTap), int'(e.best));
          check("windowLen", int'(windowLen), int'(e.wlen));
          check("bitslip_count", nslip, e.slips);
          check("en_vtc_at_end", int'(EN_VTC), 1);
        end
        done_cnt++;
      end
    end
    prev_done = initDone;
    prev_err  = initError;
  end

  // ---------------- driver ----------------
  task automatic run_case(input logic [31:0] m, input int r, input bit nm, input bit chk_first);
    int  start_cnt;
    bit  seen;
    good_mask = m;
    rot       = r;
    nomatch   = nm;
    exp_q.push_back(model(m, r, nm));
    start_cnt = done_cnt;
    @(negedge clk);
    initStart = 1'b1;
    @(negedge clk);
    initStart = 1'b0;
    if (chk_first) begin
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (rstIDelay) begin
          seen = 1'b1;
          check("restart_first_tap", int'(tapIn), 0);
        end
      end
      check("restart_first_load_seen", int'(seen), 1);
    end
    for (int i = 0; i < kRunMax && done_cnt == start_cnt; i++) @(negedge clk);
    if (done_cnt == start_cnt) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got no completion expected one within %0d cycles", kRunMax);
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tapIn"}, int'(tapIn), 0);
    check({tag, "_rstIDelay"}, int'(rstIDelay), 0);
    check({tag, "_EN_VTC"}, int'(EN_VTC), 1);
    check({tag, "_bitslip"}, int'(bitslip), 0);
    check({tag, "_initDone"}, int'(initDone), 0);
    check({tag, "_initError"}, int'(initError), 0);
    check({tag, "_bestTap"}, int'(bestTap), 0);
    check({tag, "_windowLen"}, int'(windowLen), 0);
  endtask

  initial begin
    logic [31:0] rmask;
    int          st;
    int          len;
    bit          seen;
    int          bad_cyc;

    ioReset   = 1'b1;
    initStart = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    ioReset = 1'b0;
    repeat (2) @(negedge clk);

    run_case(32'h000F_FC00, 0, 1'b0, 1'b0);   // eye 10..19, already aligned
    run_case(32'h0000_001C, 0, 1'b0, 1'b0);   // eye 2..4 too narrow
    run_case(32'h03F0_01F8, 0, 1'b0, 1'b0);   // equal eyes 3..8 and 20..25
    run_case(32'hF000_0000, 0, 1'b0, 1'b0);   // eye at the top edge 28..31
    run_case(32'h000F_FC00, 3, 1'b0, 1'b0);   // idle word rotated by 3
    run_case(32'h000F_FC00, 0, 1'b1, 1'b0);   // pattern never matches

    // Abort mid-scan at tap 12, then restart.
    good_mask = 32'h000F_FC00;
    rot       = 0;
    nomatch   = 1'b0;
    @(negedge clk);
    initStart = 1'b1;
    @(negedge clk);
    initStart = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (rstIDelay && tapIn == 5'd12) seen = 1'b1;
    end
    check("tap12_reached", int'(seen), 1);
    repeat (20) @(negedge clk);
    ioReset = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    @(negedge clk);
    initStart = 1'b1;                          // coincident with reset: must be ignored
    @(negedge clk);
    initStart = 1'b0;
    ioReset   = 1'b0;
    bad_cyc   = 0;
    repeat (40) begin
      @(negedge clk);
      if (!EN_VTC || rstIDelay || bitslip) bad_cyc++;
    end
    check("idle_after_reset", bad_cyc, 0);
    run_case(32'h000F_FC00, 0, 1'b0, 1'b1);

    // Randomised eye placement, glitch pattern and rotation.
    rmask = $urandom & $urandom & $urandom;
    len   = $urandom_range(3, 10);
    st    = $urandom_range(0, 31);
    for (int t = st; t < st + len && t < 32; t++) rmask[t] = 1'b1;
    run_case(rmask, $urandom_range(0, 7), 1'b0, 1'b0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
